// File: rtl/axil_register_slice_if.sv
// AXI4-Lite bundle shared by both sides of the register slice.
// master drives requests (AW/W/AR) and response-ready; slave drives the rest.
interface axil_register_slice_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_register_slice.sv
// Full AXI4-Lite register slice: one registered 2-entry skid buffer per channel,
// so no output depends combinationally on any input.
module axil_register_slice_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         sync_rst_n,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_in_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_out_data
);
    logic         r_main_valid;
    logic         r_skid_valid;
    logic         r_in_ready;
    logic [W-1:0] r_main_data;
    logic [W-1:0] r_skid_data;
    logic         w_push;
    logic         w_pop;

    assign w_push      = i_in_valid & r_in_ready;
    assign w_pop       = r_main_valid & i_out_ready;
    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_main_valid;
    assign o_out_data  = r_main_data;

    // in_ready tracks the next skid state, so it falls on the same edge the skid fills
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else if (w_pop || !r_main_valid) begin
            r_in_ready <= 1'b1;
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_push) begin
                r_main_data  <= i_in_data;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_push) begin
            r_skid_data  <= i_in_data;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end else begin
            r_in_ready <= !r_skid_valid;
        end
    end
endmodule

module axil_register_slice #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  sync_rst_n,
    axil_register_slice_if.slave  s_axi,
    axil_register_slice_if.master m_axi
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH+STRB_W-1:0] w_w_in;
    logic [DATA_WIDTH+STRB_W-1:0] w_w_out;
    logic [DATA_WIDTH+1:0]        w_r_in;
    logic [DATA_WIDTH+1:0]        w_r_out;

    assign w_w_in                     = {s_axi.wdata, s_axi.wstrb};
    assign {m_axi.wdata, m_axi.wstrb} = w_w_out;
    assign w_r_in                     = {m_axi.rdata, m_axi.rresp};
    assign {s_axi.rdata, s_axi.rresp} = w_r_out;

    axil_register_slice_skid #(.W(ADDR_WIDTH)) u_aw (
        .clk, .sync_rst_n,
        .i_in_valid (s_axi.awvalid), .o_in_ready (s_axi.awready), .i_in_data (s_axi.awaddr),
        .o_out_valid(m_axi.awvalid), .i_out_ready(m_axi.awready), .o_out_data(m_axi.awaddr)
    );

    axil_register_slice_skid #(.W(DATA_WIDTH+STRB_W)) u_w (
        .clk, .sync_rst_n,
        .i_in_valid (s_axi.wvalid), .o_in_ready (s_axi.wready), .i_in_data (w_w_in),
        .o_out_valid(m_axi.wvalid), .i_out_ready(m_axi.wready), .o_out_data(w_w_out)
    );

    axil_register_slice_skid #(.W(2)) u_b (
        .clk, .sync_rst_n,
        .i_in_valid (m_axi.bvalid), .o_in_ready (m_axi.bready), .i_in_data (m_axi.bresp),
        .o_out_valid(s_axi.bvalid), .i_out_ready(s_axi.bready), .o_out_data(s_axi.bresp)
    );

    axil_register_slice_skid #(.W(ADDR_WIDTH)) u_ar (
        .clk, .sync_rst_n,
        .i_in_valid (s_axi.arvalid), .o_in_ready (s_axi.arready), .i_in_data (s_axi.araddr),
        .o_out_valid(m_axi.arvalid), .i_out_ready(m_axi.arready), .o_out_data(m_axi.araddr)
    );

    axil_register_slice_skid #(.W(DATA_WIDTH+2)) u_r (
        .clk, .sync_rst_n,
        .i_in_valid (m_axi.rvalid), .o_in_ready (m_axi.rready), .i_in_data (w_r_in),
        .o_out_valid(s_axi.rvalid), .i_out_ready(s_axi.rready), .o_out_data(w_r_out)
    );
endmodule

// File: tb/tb_axil_register_slice.sv
// Bench for axil_register_slice: directed scenarios plus random traffic on all
// five channels against per-channel FIFO reference queues.
module tb_axil_register_slice;
    logic clk = 1'b0;
    logic sync_rst_n = 1'b0;
    always #5 clk = ~clk;

    axil_register_slice_if s_if ();
    axil_register_slice_if m_if ();

    axil_register_slice dut (
        .clk       (clk),
        .sync_rst_n(sync_rst_n),
        .s_axi     (s_if),
        .m_axi     (m_if)
    );

    // channel index: 0=AW 1=W 2=AR (host->decoder), 3=B 4=R (decoder->host)
    logic [4:0]  src_v = '0;
    logic [35:0] src_p [5];
    logic [4:0]  snk_r = '1;
    logic [4:0]  in_rdy;
    logic [4:0]  out_v;
    logic [35:0] out_p [5];

    assign s_if.awvalid = src_v[0];
    assign s_if.awaddr  = src_p[0][31:0];
    assign s_if.wvalid  = src_v[1];
    assign {s_if.wdata, s_if.wstrb} = src_p[1];
    assign s_if.arvalid = src_v[2];
    assign s_if.araddr  = src_p[2][31:0];
    assign m_if.bvalid  = src_v[3];
    assign m_if.bresp   = src_p[3][1:0];
    assign m_if.rvalid  = src_v[4];
    assign {m_if.rdata, m_if.rresp} = src_p[4][33:0];

    assign m_if.awready = snk_r[0];
    assign m_if.wready  = snk_r[1];
    assign m_if.arready = snk_r[2];
    assign s_if.bready  = snk_r[3];
    assign s_if.rready  = snk_r[4];

    assign in_rdy = {m_if.rready, m_if.bready, s_if.arready, s_if.wready, s_if.awready};
    assign out_v  = {s_if.rvalid, s_if.bvalid, m_if.arvalid, m_if.wvalid, m_if.awvalid};
    assign out_p[0] = {4'b0, m_if.awaddr};
    assign out_p[1] = {m_if.wdata, m_if.wstrb};
    assign out_p[2] = {4'b0, m_if.araddr};
    assign out_p[3] = {34'b0, s_if.bresp};
    assign out_p[4] = {2'b0, s_if.rdata, s_if.rresp};

    int n_cmp = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        src_v = '0;
        snk_r = '1;
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [35:0] ch_mask(input int c);
        case (c)
            1:       return 36'hF_FFFF_FFFF;
            3:       return 36'h3;
            4:       return 36'h3_FFFF_FFFF;
            default: return 36'h0_FFFF_FFFF;
        endcase
    endfunction

    task automatic test_reset();
        sync_rst_n = 1'b0;
        src_v = '1;
        for (int c = 0; c < 5; c++) src_p[c] = ch_mask(c);
        tick();
        tick();
        n_cmp++;
        if (out_v !== 5'b0) begin
            $display("FAIL reset_valids: got %b expected %b", out_v, 5'b0); n_err++;
        end
        n_cmp++;
        if (in_rdy !== 5'b0) begin
            $display("FAIL reset_readies: got %b expected %b", in_rdy, 5'b0); n_err++;
        end
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (out_p[c] !== 36'h0) begin
                $display("FAIL reset_payload ch%0d: got %h expected 0", c, out_p[c]); n_err++;
            end
        end
        src_v = '0;
        sync_rst_n = 1'b1;
        tick();
        n_cmp++;
        if (in_rdy !== 5'b11111) begin
            $display("FAIL reset_release_readies: got %b expected %b", in_rdy, 5'b11111); n_err++;
        end
        n_cmp++;
        if (out_v !== 5'b0) begin
            $display("FAIL reset_release_valids: got %b expected %b", out_v, 5'b0); n_err++;
        end
    endtask

    task automatic test_single_write();
        snk_r[0] = 1'b0;
        snk_r[1] = 1'b0;
        src_p[0] = 36'h0_0000_0600;
        src_p[1] = {32'h0000_0001, 4'hF};
        src_v[0] = 1'b1;
        src_v[1] = 1'b1;
        n_cmp++;
        if (out_v[1:0] !== 2'b00) begin
            $display("FAIL write_pre_edge: got %b expected %b", out_v[1:0], 2'b00); n_err++;
        end
        tick();
        src_v[1:0] = 2'b00;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (out_v[0] !== 1'b1 || out_p[0] !== 36'h0_0000_0600) begin
                $display("FAIL write_aw cyc%0d: got v=%b a=%h expected v=1 a=600", k, out_v[0], out_p[0]); n_err++;
            end
            n_cmp++;
            if (out_v[1] !== 1'b1 || out_p[1] !== {32'h1, 4'hF}) begin
                $display("FAIL write_w cyc%0d: got v=%b d=%h expected v=1 d=%h", k, out_v[1], out_p[1], {32'h1, 4'hF}); n_err++;
            end
            tick();
        end
        snk_r[1:0] = 2'b11;
        tick();
        n_cmp++;
        if (out_v[1:0] !== 2'b00) begin
            $display("FAIL write_drain: got %b expected %b", out_v[1:0], 2'b00); n_err++;
        end
        snk_r[3] = 1'b0;
        src_p[3] = 36'h0;
        src_v[3] = 1'b1;
        tick();
        src_v[3] = 1'b0;
        n_cmp++;
        if (out_v[3] !== 1'b1 || out_p[3] !== 36'h0) begin
            $display("FAIL write_b: got v=%b r=%h expected v=1 r=0", out_v[3], out_p[3]); n_err++;
        end
        snk_r[3] = 1'b1;
        tick();
        n_cmp++;
        if (out_v[3] !== 1'b0) begin
            $display("FAIL write_b_drain: got %b expected 0", out_v[3]); n_err++;
        end
    endtask

    task automatic test_single_read();
        snk_r[2] = 1'b0;
        src_p[2] = 36'h0_0000_0700;
        src_v[2] = 1'b1;
        tick();
        src_v[2] = 1'b0;
        n_cmp++;
        if (out_v[2] !== 1'b1 || out_p[2] !== 36'h0_0000_0700) begin
            $display("FAIL read_ar: got v=%b a=%h expected v=1 a=700", out_v[2], out_p[2]); n_err++;
        end
        snk_r[2] = 1'b1;
        snk_r[4] = 1'b0;
        src_p[4] = {2'b0, 32'hDEAD_BEEF, 2'b00};
        src_v[4] = 1'b1;
        tick();
        src_v[4] = 1'b0;
        n_cmp++;
        if (out_v[4] !== 1'b1 || out_p[4] !== {2'b0, 32'hDEAD_BEEF, 2'b00}) begin
            $display("FAIL read_r: got v=%b d=%h expected v=1 d=%h", out_v[4], out_p[4], {2'b0, 32'hDEAD_BEEF, 2'b00}); n_err++;
        end
        n_cmp++;
        if (out_v[2] !== 1'b0) begin
            $display("FAIL read_ar_drain: got %b expected 0", out_v[2]); n_err++;
        end
        snk_r[4] = 1'b1;
        tick();
    endtask

    task automatic test_backpressure();
        logic [35:0] got [$];
        logic [35:0] exp_a [3];
        exp_a[0] = 36'h100; exp_a[1] = 36'h104; exp_a[2] = 36'h108;
        snk_r[2] = 1'b0;
        src_v[2] = 1'b1;
        src_p[2] = 36'h100;
        tick();
        src_p[2] = 36'h104;
        tick();
        src_p[2] = 36'h108;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (in_rdy[2] !== 1'b0 || out_v[2] !== 1'b1 || out_p[2] !== 36'h100) begin
                $display("FAIL bp_hold cyc%0d: got rdy=%b v=%b a=%h expected rdy=0 v=1 a=100", k, in_rdy[2], out_v[2], out_p[2]); n_err++;
            end
            tick();
        end
        snk_r[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic acc;
            acc = src_v[2] & in_rdy[2];
            if (out_v[2]) got.push_back(out_p[2]);
            tick();
            if (acc) src_v[2] = 1'b0;
        end
        n_cmp++;
        if (got.size() != 3) begin
            $display("FAIL bp_count: got %0d expected 3", got.size()); n_err++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (got[i] !== exp_a[i]) begin
                    $display("FAIL bp_order beat%0d: got %h expected %h", i, got[i], exp_a[i]); n_err++;
                end
            end
        end
    endtask

    task automatic test_throughput();
        logic [35:0] d [16];
        snk_r[1] = 1'b1;
        for (int k = 0; k < 16; k++) d[k] = {$urandom, 4'($urandom)};
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) begin
                src_p[1] = d[k];
                src_v[1] = 1'b1;
                n_cmp++;
                if (in_rdy[1] !== 1'b1) begin
                    $display("FAIL tput_ready beat%0d: got %b expected 1", k, in_rdy[1]); n_err++;
                end
            end else begin
                src_v[1] = 1'b0;
            end
            if (k > 0) begin
                n_cmp++;
                if (out_v[1] !== 1'b1 || out_p[1] !== d[k-1]) begin
                    $display("FAIL tput_out beat%0d: got v=%b d=%h expected v=1 d=%h", k - 1, out_v[1], out_p[1], d[k-1]); n_err++;
                end
            end
            tick();
        end
        n_cmp++;
        if (out_v[1] !== 1'b0) begin
            $display("FAIL tput_end: got %b expected 0", out_v[1]); n_err++;
        end
    endtask

    task automatic test_reset_midop();
        snk_r = 5'b00000;
        src_v = 5'b11111;
        for (int c = 0; c < 5; c++) src_p[c] = {$urandom, $urandom} & ch_mask(c);
        tick();
        tick();
        n_cmp++;
        if (in_rdy !== 5'b0 || out_v !== 5'b11111) begin
            $display("FAIL midop_full: got rdy=%b v=%b expected rdy=00000 v=11111", in_rdy, out_v); n_err++;
        end
        #2 sync_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_v !== 5'b0 || in_rdy !== 5'b0) begin
            $display("FAIL midop_async: got v=%b rdy=%b expected 0", out_v, in_rdy); n_err++;
        end
        src_v = '0;
        snk_r = '1;
        tick();
        sync_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (out_v !== 5'b0) begin
                $display("FAIL midop_stale cyc%0d: got %b expected 0", k, out_v); n_err++;
            end
        end
    endtask

    task automatic test_random();
        logic [35:0] q [5][$];
        for (int cyc = 0; cyc < 612; cyc++) begin
            bit drain;
            drain = (cyc >= 600);
            for (int c = 0; c < 5; c++) begin
                if (drain) begin
                    src_v[c] = 1'b0;
                    snk_r[c] = 1'b1;
                end else begin
                    if (!src_v[c]) begin
                        src_v[c] = 1'($urandom_range(0, 1));
                        src_p[c] = {$urandom, $urandom} & ch_mask(c);
                    end
                    snk_r[c] = ($urandom_range(0, 3) != 0);
                end
            end
            #0;
            for (int c = 0; c < 5; c++) begin
                if (src_v[c] && in_rdy[c]) q[c].push_back(src_p[c]);
                if (out_v[c]) begin
                    n_cmp++;
                    if (q[c].size() == 0) begin
                        $display("FAIL rand_extra ch%0d: got %h expected no beat", c, out_p[c]); n_err++;
                    end else begin
                        if (out_p[c] !== q[c][0]) begin
                            $display("FAIL rand_data ch%0d: got %h expected %h", c, out_p[c], q[c][0]); n_err++;
                        end
                        if (snk_r[c]) void'(q[c].pop_front());
                    end
                end
            end
            tick();
            for (int c = 0; c < 5; c++)
                if (src_v[c] && q[c].size() > 0 && q[c][$] === src_p[c]) src_v[c] = 1'b0;
        end
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (q[c].size() != 0) begin
                $display("FAIL rand_lost ch%0d: got %0d beats left expected 0", c, q[c].size()); n_err++;
            end
        end
    endtask

    initial begin
        for (int c = 0; c < 5; c++) src_p[c] = '0;
        test_reset();
        idle(2);
        test_single_write();
        idle(2);
        test_single_read();
        idle(2);
        test_backpressure();
        idle(2);
        test_throughput();
        idle(2);
        test_reset_midop();
        idle(2);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
